// File: rtl/pu_or1k_spr_initiator.sv
// SPR bus initiator: turns single read/write or multi-beat sweep requests into
// one-at-a-time SPR bus accesses with an ack timeout, returning one response per beat.
module pu_or1k_spr_initiator #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int SWEEP_COUNT    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_sweep,
  input  logic [15:0] req_addr,
  input  logic [31:0] req_dat,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        rsp_last,
  output logic        spr_access_o,
  output logic        spr_we_o,
  output logic        spr_re_o,
  output logic [15:0] spr_addr_o,
  output logic [31:0] spr_dat_o,
  input  logic        spr_bus_ack_i,
  input  logic [31:0] spr_dat_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [4:0] LAST_BEAT = 5'(SWEEP_COUNT - 1);
  localparam logic [7:0] TO_LAST   = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_r;
  logic        we_r;
  logic        sweep_r;
  logic [15:0] addr_r;
  logic [4:0]  beat_r;
  logic [7:0]  tcnt_r;

  logic [4:0]  beat_next_s;
  logic [15:0] addr_next_s;

  assign beat_next_s = beat_r + 5'd1;
  assign addr_next_s = addr_r + {11'd0, beat_next_s};

  // Control FSM; every output is a register so the bus sees glitch-free, stable values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_dat      <= 32'd0;
      rsp_err      <= 1'b0;
      rsp_last     <= 1'b0;
      spr_access_o <= 1'b0;
      spr_we_o     <= 1'b0;
      spr_re_o     <= 1'b0;
      spr_addr_o   <= 16'd0;
      spr_dat_o    <= 32'd0;
      we_r         <= 1'b0;
      sweep_r      <= 1'b0;
      addr_r       <= 16'd0;
      beat_r       <= 5'd0;
      tcnt_r       <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          // req_ready re-arms one cycle after a response completes
          if (!req_ready) begin
            req_ready <= 1'b1;
          end else if (req_valid) begin
            req_ready    <= 1'b0;
            we_r         <= req_we & ~req_sweep;
            sweep_r      <= req_sweep;
            addr_r       <= req_addr;
            beat_r       <= 5'd0;
            tcnt_r       <= 8'd0;
            state_r      <= ACCESS;
            spr_access_o <= 1'b1;
            spr_we_o     <= req_we & ~req_sweep;
            spr_re_o     <= ~(req_we & ~req_sweep);
            spr_addr_o   <= req_addr;
            spr_dat_o    <= (req_we & ~req_sweep) ? req_dat : 32'd0;
          end else begin
            req_ready <= 1'b1;
          end
        end

        ACCESS: begin
          if (spr_bus_ack_i || (tcnt_r == TO_LAST)) begin
            // an ack in the final cycle takes priority over the timeout
            rsp_dat      <= (spr_bus_ack_i && !we_r) ? spr_dat_i : 32'd0;
            rsp_err      <= ~spr_bus_ack_i;
            rsp_last     <= ~spr_bus_ack_i | ~sweep_r | (beat_r == LAST_BEAT);
            rsp_valid    <= 1'b1;
            state_r      <= RESP;
            spr_access_o <= 1'b0;
            spr_we_o     <= 1'b0;
            spr_re_o     <= 1'b0;
            spr_addr_o   <= 16'd0;
            spr_dat_o    <= 32'd0;
          end else begin
            tcnt_r <= tcnt_r + 8'd1;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            // rsp_last already covers errored beats, so an error aborts the sweep
            if (sweep_r && !rsp_last) begin
              beat_r       <= beat_next_s;
              tcnt_r       <= 8'd0;
              state_r      <= ACCESS;
              spr_access_o <= 1'b1;
              spr_we_o     <= 1'b0;
              spr_re_o     <= 1'b1;
              spr_addr_o   <= addr_next_s;
              spr_dat_o    <= 32'd0;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            rsp_valid <= 1'b1;
          end
        end

        default: begin
          state_r      <= IDLE;
          req_ready    <= 1'b0;
          rsp_valid    <= 1'b0;
          spr_access_o <= 1'b0;
          spr_we_o     <= 1'b0;
          spr_re_o     <= 1'b0;
          spr_addr_o   <= 16'd0;
          spr_dat_o    <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pu_or1k_spr_initiator.sv
// Self-checking bench for pu_or1k_spr_initiator: a programmable SPR responder model,
// plus access and response scoreboards fed by the stimulus tasks.
module tb_pu_or1k_spr_initiator;

  localparam int TO = 16;
  localparam int SW = 8;

  typedef struct packed {
    logic [31:0] dat;
    logic        err;
    logic        last;
  } rsp_t;

  typedef struct packed {
    logic [15:0] addr;
    logic        we;
    logic [31:0] dat;
  } acc_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic        req_sweep = 1'b0;
  logic [15:0] req_addr = 16'd0;
  logic [31:0] req_dat = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        rsp_last;
  logic        spr_access_o;
  logic        spr_we_o;
  logic        spr_re_o;
  logic [15:0] spr_addr_o;
  logic [31:0] spr_dat_o;
  logic        spr_bus_ack_i;
  logic [31:0] spr_dat_i;

  int errors = 0;
  int checks = 0;

  rsp_t exp_rsp_q[$];
  acc_t exp_acc_q[$];

  // responder configuration
  int          ack_delay = 0;
  bit          ack_off = 1'b0;
  bit          noack_en = 1'b0;
  logic [15:0] noack_addr = 16'd0;
  bit          data_mode = 1'b0;
  logic [31:0] const_data = 32'd0;
  int          wait_cnt = 0;

  // monitor bookkeeping
  int beat_seen = 0;
  int acc_starts = 0;
  int last_dwell = 0;
  int stall_cycles = 0;
  int stall_beat = -1;
  int stall_left = 0;

  always #5 clk = ~clk;

  pu_or1k_spr_initiator #(.TIMEOUT_CYCLES(TO), .SWEEP_COUNT(SW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_sweep(req_sweep),
    .req_addr(req_addr), .req_dat(req_dat),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .rsp_last(rsp_last),
    .spr_access_o(spr_access_o), .spr_we_o(spr_we_o), .spr_re_o(spr_re_o),
    .spr_addr_o(spr_addr_o), .spr_dat_o(spr_dat_o),
    .spr_bus_ack_i(spr_bus_ack_i), .spr_dat_i(spr_dat_i)
  );

  // responder counts unacked access cycles of the current dwell
  always @(posedge clk) begin
    if (spr_access_o && !spr_bus_ack_i) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  assign spr_bus_ack_i = spr_access_o && !ack_off && !(noack_en && spr_addr_o == noack_addr)
                         && (wait_cnt >= ack_delay);
  assign spr_dat_i = data_mode ? ({29'd0, spr_addr_o[2:0]} * 32'd10) : const_data;

  task automatic push_rsp(input logic [31:0] d, input logic e, input logic l);
    rsp_t r;
    r.dat = d; r.err = e; r.last = l;
    exp_rsp_q.push_back(r);
  endtask

  task automatic push_acc(input logic [15:0] a, input logic w, input logic [31:0] d);
    acc_t x;
    x.addr = a; x.we = w; x.dat = d;
    exp_acc_q.push_back(x);
  endtask

  task automatic monitor_loop();
    acc_t e;
    rsp_t r;
    rsp_t held;
    bit in_acc = 1'b0;
    bit stalled = 1'b0;
    logic [49:0] h_acc;
    int dwell = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_acc = 1'b0;
        stalled = 1'b0;
      end else begin
        if (spr_access_o) begin
          if (!in_acc) begin
            in_acc = 1'b1; dwell = 1; acc_starts++;
            h_acc = {spr_addr_o, spr_we_o, spr_re_o, spr_dat_o};
            checks++;
            if (exp_acc_q.size() == 0) begin
              errors++;
              $display("FAIL unexpected_access got addr=%h expected none", spr_addr_o);
            end else begin
              e = exp_acc_q.pop_front();
              if (spr_addr_o !== e.addr || spr_we_o !== e.we || spr_re_o !== ~e.we || spr_dat_o !== e.dat) begin
                errors++;
                $display("FAIL access got addr=%h we=%b re=%b dat=%h expected addr=%h we=%b re=%b dat=%h",
                         spr_addr_o, spr_we_o, spr_re_o, spr_dat_o, e.addr, e.we, ~e.we, e.dat);
              end
            end
          end else begin
            dwell++;
            checks++;
            if ({spr_addr_o, spr_we_o, spr_re_o, spr_dat_o} !== h_acc) begin
              errors++;
              $display("FAIL access_stable got %h expected %h",
                       {spr_addr_o, spr_we_o, spr_re_o, spr_dat_o}, h_acc);
            end
          end
        end else begin
          if (in_acc) begin
            in_acc = 1'b0;
            last_dwell = dwell;
          end
          checks++;
          if ({spr_we_o, spr_re_o, spr_addr_o, spr_dat_o} !== 50'd0) begin
            errors++;
            $display("FAIL spr_idle got we=%b re=%b addr=%h dat=%h expected all zero",
                     spr_we_o, spr_re_o, spr_addr_o, spr_dat_o);
          end
        end
        if (rsp_valid) begin
          checks++;
          if (spr_access_o !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL rsp_exclusive got access=%b req_ready=%b expected 0 0", spr_access_o, req_ready);
          end
          if (stalled) begin
            checks++;
            if ({rsp_dat, rsp_err, rsp_last} !== held) begin
              errors++;
              $display("FAIL rsp_hold got %h expected %h", {rsp_dat, rsp_err, rsp_last}, held);
            end
          end
          if (rsp_ready) begin
            stalled = 1'b0;
            beat_seen++;
            checks++;
            if (exp_rsp_q.size() == 0) begin
              errors++;
              $display("FAIL unexpected_rsp got dat=%h err=%b last=%b expected none", rsp_dat, rsp_err, rsp_last);
            end else begin
              r = exp_rsp_q.pop_front();
              if ({rsp_dat, rsp_err, rsp_last} !== r) begin
                errors++;
                $display("FAIL rsp got dat=%h err=%b last=%b expected dat=%h err=%b last=%b",
                         rsp_dat, rsp_err, rsp_last, r.dat, r.err, r.last);
              end
            end
          end else begin
            stalled = 1'b1;
            held = {rsp_dat, rsp_err, rsp_last};
            stall_cycles++;
          end
        end else begin
          stalled = 1'b0;
        end
      end
    end
  endtask

  task automatic ready_driver();
    forever begin
      @(posedge clk); #1;
      if (rsp_valid && beat_seen == stall_beat && stall_left > 0) begin
        rsp_ready = 1'b0;
        stall_left--;
      end else begin
        rsp_ready = 1'b1;
      end
    end
  endtask

  task automatic send_req(input logic we, input logic sw, input logic [15:0] a, input logic [31:0] d);
    int n = 0;
    @(posedge clk); #1;
    while (!req_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!req_ready) begin
      errors++;
      $display("FAIL req_ready_wait got 0 expected 1");
    end else begin
      req_valid = 1'b1; req_we = we; req_sweep = sw; req_addr = a; req_dat = d;
      @(posedge clk); #1;
      req_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(exp_rsp_q.size() == 0 && req_ready && !rsp_valid) && n < 400);
    checks++;
    if (exp_rsp_q.size() != 0 || !req_ready) begin
      errors++;
      $display("FAIL %s_done got pending=%0d req_ready=%b expected 0 1", name, exp_rsp_q.size(), req_ready);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs got req_ready=%b rsp_valid=%b expected 1 0", req_ready, rsp_valid);
    end
    checks++;
    if ({rsp_dat, rsp_err, rsp_last} !== 34'd0) begin
      errors++;
      $display("FAIL reset_rsp got %h expected 0", {rsp_dat, rsp_err, rsp_last});
    end
    checks++;
    if ({spr_access_o, spr_we_o, spr_re_o, spr_addr_o, spr_dat_o} !== 51'd0) begin
      errors++;
      $display("FAIL reset_spr got %h expected 0", {spr_access_o, spr_we_o, spr_re_o, spr_addr_o, spr_dat_o});
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    ack_delay = 0; data_mode = 1'b0; const_data = 32'h0000_002A;
    push_acc(16'h3801, 1'b0, 32'd0);
    push_rsp(32'h0000_002A, 1'b0, 1'b1);
    send_req(1'b0, 1'b0, 16'h3801, 32'h1234_5678);
    @(negedge clk);
    checks++;
    if (spr_access_o !== 1'b1) begin
      errors++;
      $display("FAIL read_latency_access got %b expected 1", spr_access_o);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL read_latency_rsp got %b expected 1", rsp_valid);
    end
    wait_done("single_read");
    checks++;
    if (last_dwell != 1) begin
      errors++;
      $display("FAIL read_dwell got %0d expected 1", last_dwell);
    end
  endtask

  task automatic test_single_write();
    ack_delay = 3; data_mode = 1'b0; const_data = 32'hDEAD_BEEF;
    push_acc(16'h3808, 1'b1, 32'h0000_0101);
    push_rsp(32'd0, 1'b0, 1'b1);
    send_req(1'b1, 1'b0, 16'h3808, 32'h0000_0101);
    wait_done("single_write");
    checks++;
    if (last_dwell != 4) begin
      errors++;
      $display("FAIL write_dwell got %0d expected 4", last_dwell);
    end
  endtask

  task automatic test_sweep();
    ack_delay = 0; data_mode = 1'b1;
    for (int i = 0; i < SW; i++) begin
      push_acc(16'h3800 + 16'(i), 1'b0, 32'd0);
      push_rsp(32'(i) * 32'd10, 1'b0, i == SW - 1);
    end
    // req_we is set on purpose: a sweep must still read
    send_req(1'b1, 1'b1, 16'h3800, 32'hFFFF_FFFF);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (spr_access_o !== 1'b1 || spr_addr_o !== 16'h3801) begin
      errors++;
      $display("FAIL sweep_beat1_latency got access=%b addr=%h expected 1 3801", spr_access_o, spr_addr_o);
    end
    wait_done("sweep");
  endtask

  task automatic test_timeout();
    ack_off = 1'b1; data_mode = 1'b0; const_data = 32'h0000_0055;
    push_acc(16'h3810, 1'b0, 32'd0);
    push_rsp(32'd0, 1'b1, 1'b1);
    send_req(1'b0, 1'b0, 16'h3810, 32'd0);
    wait_done("timeout");
    checks++;
    if (last_dwell != TO) begin
      errors++;
      $display("FAIL timeout_dwell got %0d expected %0d", last_dwell, TO);
    end
    ack_off = 1'b0; ack_delay = TO - 1;
    push_acc(16'h3811, 1'b0, 32'd0);
    push_rsp(32'h0000_0055, 1'b0, 1'b1);
    send_req(1'b0, 1'b0, 16'h3811, 32'd0);
    wait_done("late_ack");
    checks++;
    if (last_dwell != TO) begin
      errors++;
      $display("FAIL late_ack_dwell got %0d expected %0d", last_dwell, TO);
    end
    ack_delay = 0;
  endtask

  task automatic test_stall_and_abort();
    int sc0;
    ack_delay = 0; data_mode = 1'b1;
    for (int i = 0; i < SW; i++) begin
      push_acc(16'h3820 + 16'(i), 1'b0, 32'd0);
      push_rsp(32'(i) * 32'd10, 1'b0, i == SW - 1);
    end
    stall_beat = beat_seen + 2;
    stall_left = 5;
    sc0 = stall_cycles;
    send_req(1'b0, 1'b1, 16'h3820, 32'd0);
    wait_done("stall");
    checks++;
    if (stall_cycles - sc0 != 5) begin
      errors++;
      $display("FAIL stall_cycles got %0d expected 5", stall_cycles - sc0);
    end
    stall_beat = -1;
    noack_en = 1'b1; noack_addr = 16'h3833;
    for (int i = 0; i < 4; i++) push_acc(16'h3830 + 16'(i), 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) push_rsp(32'(i) * 32'd10, 1'b0, 1'b0);
    push_rsp(32'd0, 1'b1, 1'b1);
    send_req(1'b0, 1'b1, 16'h3830, 32'd0);
    wait_done("abort");
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (exp_acc_q.size() != 0 || last_dwell != TO) begin
      errors++;
      $display("FAIL abort_accesses got pending=%0d dwell=%0d expected 0 %0d", exp_acc_q.size(), last_dwell, TO);
    end
    noack_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n = 0;
    ack_delay = 0; data_mode = 1'b0; const_data = 32'h0000_0011;
    push_acc(16'h3840, 1'b0, 32'd0);
    push_rsp(32'h0000_0011, 1'b0, 1'b1);
    send_req(1'b0, 1'b0, 16'h3840, 32'd0);
    push_acc(16'h3841, 1'b0, 32'd0);
    push_rsp(32'h0000_0011, 1'b0, 1'b1);
    req_valid = 1'b1; req_we = 1'b0; req_sweep = 1'b0; req_addr = 16'h3841;
    do begin
      @(negedge clk);
      n++;
    end while (!(rsp_valid && rsp_ready) && n < 50);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || spr_access_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap got req_ready=%b access=%b expected 0 0", req_ready, spr_access_o);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || spr_access_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_rearm got req_ready=%b access=%b expected 1 0", req_ready, spr_access_o);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (spr_access_o !== 1'b1 || spr_addr_o !== 16'h3841) begin
      errors++;
      $display("FAIL b2b_second got access=%b addr=%h expected 1 3841", spr_access_o, spr_addr_o);
    end
    wait_done("back_to_back");
  endtask

  task automatic test_wrap_reset();
    logic [15:0] a;
    int n = 0;
    int seen0;
    int starts0;
    ack_delay = 0; data_mode = 1'b1;
    for (int i = 0; i < SW; i++) begin
      a = 16'hFFFE + 16'(i);
      push_acc(a, 1'b0, 32'd0);
      push_rsp({29'd0, a[2:0]} * 32'd10, 1'b0, i == SW - 1);
    end
    send_req(1'b0, 1'b1, 16'hFFFE, 32'd0);
    wait_done("wrap");
    ack_delay = 3;
    push_acc(16'hFFFE, 1'b0, 32'd0);
    push_acc(16'hFFFF, 1'b0, 32'd0);
    push_rsp(32'd60, 1'b0, 1'b0);
    send_req(1'b0, 1'b1, 16'hFFFE, 32'd0);
    do begin
      @(negedge clk);
      n++;
    end while (!(spr_access_o && spr_addr_o == 16'hFFFF) && n < 100);
    checks++;
    if (!(spr_access_o && spr_addr_o == 16'hFFFF)) begin
      errors++;
      $display("FAIL wrap_beat1 got access=%b addr=%h expected 1 ffff", spr_access_o, spr_addr_o);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({spr_access_o, spr_we_o, spr_re_o, spr_addr_o, spr_dat_o} !== 51'd0) begin
      errors++;
      $display("FAIL async_reset_spr got %h expected 0", {spr_access_o, spr_we_o, spr_re_o, spr_addr_o, spr_dat_o});
    end
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || {rsp_dat, rsp_err, rsp_last} !== 34'd0) begin
      errors++;
      $display("FAIL async_reset_rsp got req_ready=%b rsp_valid=%b rsp=%h expected 1 0 0",
               req_ready, rsp_valid, {rsp_dat, rsp_err, rsp_last});
    end
    exp_acc_q.delete();
    exp_rsp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    seen0 = beat_seen;
    starts0 = acc_starts;
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (beat_seen != seen0 || acc_starts != starts0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_quiet got rsps=%0d accesses=%0d req_ready=%b expected 0 0 1",
               beat_seen - seen0, acc_starts - starts0, req_ready);
    end
  endtask

  initial begin
    fork
      monitor_loop();
      ready_driver();
    join_none
    test_reset();
    test_single_read();
    test_single_write();
    test_sweep();
    test_timeout();
    test_stall_and_abort();
    test_back_to_back();
    test_wrap_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pu_or1k_spr_initiator.md
PU_OR1K_SPR_INITIATOR -- requirements
Module: pu_or1k_spr_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, giving the number of ACCESS cycles without ack before an error response (legal range 1..255).
REQ-002 SHALL have parameter SWEEP_COUNT, default 8, giving the number of consecutive SPR reads per sweep request (legal range 1..16).
REQ-003 SHALL have port clk  input  1  (single clock, rising edge).
REQ-004 SHALL have port rst  input  1  (reset, asynchronous, active-high).
REQ-005 SHALL have request ports req_valid in 1, req_ready out 1, req_we in 1, req_sweep in 1, req_addr in 16, req_dat in 32.
REQ-006 SHALL have response ports rsp_valid out 1, rsp_ready in 1, rsp_dat out 32, rsp_err out 1, rsp_last out 1.
REQ-007 SHALL have SPR bus ports spr_access_o out 1, spr_we_o out 1, spr_re_o out 1, spr_addr_o out 16, spr_dat_o out 32, spr_bus_ack_i in 1, spr_dat_i in 32.

Function
REQ-008 SHALL act as the SPR bus initiator: one outstanding access, responder acks combinationally in the access cycle or any later cycle.
REQ-009 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-010 IDLE: req_ready=1; on req_valid, latch we, sweep, addr and dat, clear the beat and timeout counters, and go to ACCESS. No other state SHALL assert req_ready.
REQ-011 ACCESS: spr_access_o=1 and spr_addr_o = latched addr + beat (16-bit, wraps 0xFFFF->0x0000).
REQ-012 ACCESS, single write (we=1, sweep=0): spr_we_o=1, spr_re_o=0, spr_dat_o = latched dat.
REQ-013 ACCESS, reads and sweep beats: spr_re_o=1, spr_we_o=0, spr_dat_o=0. req_we SHALL be ignored when req_sweep=1.
REQ-014 All spr_*_o SHALL be 0 outside ACCESS, and SHALL be stable for the whole ACCESS dwell.
REQ-015 Ack in ACCESS: capture rsp_dat = spr_dat_i for a read, or 0 for a write; set rsp_err=0; go to RESP next cycle.
REQ-016 Each ACCESS cycle without ack SHALL increment the timeout counter.
REQ-017 After TIMEOUT_CYCLES ACCESS cycles without ack: rsp_dat=0, rsp_err=1, go to RESP. An ack in the final cycle SHALL win over the timeout.
REQ-018 RESP: rsp_valid=1, with rsp_dat, rsp_err and rsp_last held stable until rsp_ready; spr_bus_ack_i SHALL be ignored.
REQ-019 rsp_last=1 for single requests, for the sweep beat with beat==SWEEP_COUNT-1, and for any beat with rsp_err=1.
REQ-020 RESP handshake (rsp_valid & rsp_ready): if sweep, not last, and no error, increment beat, clear the timeout counter, and go to ACCESS; otherwise go to IDLE.
REQ-021 An errored sweep beat SHALL abort the remaining beats.
REQ-022 Latency with a zero-wait responder and rsp_ready=1: request accepted at edge N; spr_access_o high during cycle N+1; rsp_valid high during cycle N+2; next sweep beat access during cycle N+3.
REQ-023 A new request SHALL NOT be accepted in the cycle the previous response completes; req_ready rises one cycle after returning to IDLE.

Reset
REQ-024 While rst=1, asynchronously: state=IDLE; req_ready=1; rsp_valid=0; rsp_dat=0; rsp_err=0; rsp_last=0; spr_access_o, spr_we_o, spr_re_o=0; spr_addr_o=0; spr_dat_o=0; counters=0.
REQ-025 Reset mid-ACCESS or mid-RESP SHALL drop spr_access_o and rsp_valid immediately, discard the transaction, and emit no response after reset.

Verification
REQ-026 Single read at 0x3801, responder acks immediately with 0x0000_002A -> one access cycle (re=1, we=0), then rsp_valid with rsp_dat=0x2A, rsp_err=0, rsp_last=1; back to IDLE.
REQ-027 Single write 0x0000_0101 at 0x3808, ack after 3 wait cycles -> spr_we_o=1, spr_dat_o=0x101 stable for 4 cycles; rsp_dat=0, rsp_err=0, rsp_last=1.
REQ-028 Sweep at base 0x3800, SWEEP_COUNT=8, responder returns addr[2:0]*10 -> 8 responses with data 0, 10, ..., 70; rsp_last only on the 8th; addresses 0x3800..0x3807.
REQ-029 Read with no ack, TIMEOUT_CYCLES=16 -> spr_access_o high for exactly 16 cycles, then rsp_err=1, rsp_dat=0, rsp_last=1. Repeat with ack in cycle 16 -> rsp_err=0.
REQ-030 Sweep with rsp_ready low 5 cycles on beat 2 -> rsp outputs stable, no SPR access during the stall. Sweep with no ack on beat 3 -> beat 3 errors with rsp_last=1 and no beat 4 access.
REQ-031 Sweep at base 0xFFFE -> addresses 0xFFFE, 0xFFFF, 0x0000, ...; assert rst during beat 1 ACCESS -> all outputs at reset values that cycle and no further responses.
